// File: rtl/outcollect.sv
// outcollect: gathers add/mul/sine completions into an in-order show-ahead FIFO; OUTCOLLECT_TAG_EN adds a 2-bit source tag.
// Latency done->result_valid is 2 cycles; out_fifo_hold throttles dispatch near full, pending data waits when full.

module outcollect_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     i_push_vld,
  input  logic [W-1:0]             i_push_dat,
  input  logic                     i_pop_vld,
  output logic [W-1:0]             o_head_dat,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  // Caller only pushes when there is room (or a pop frees a slot this cycle).
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push_vld) begin
        r_mem[r_wr_ptr] <= i_push_dat;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (i_pop_vld) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push_vld, i_pop_vld})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_count    = r_count;
endmodule

module outcollect #(
  parameter int DEPTH       = 8,
  parameter int HOLD_MARGIN = 3
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        add_done,
  input  logic        mul_done,
  input  logic        sine_done,
  input  logic [31:0] add_result,
  input  logic [31:0] mul_result,
  input  logic [31:0] sine_result,
  input  logic        result_read,
  output logic [31:0] result_data,
  output logic [1:0]  result_tag,
  output logic        result_valid,
  output logic        out_fifo_hold,
  output logic        overflow_err
);
  localparam int CW = $clog2(DEPTH) + 1;
`ifdef OUTCOLLECT_TAG_EN
  localparam int EW = 34;
`else
  localparam int EW = 32;
`endif

  // Index 0 = add, 1 = mul, 2 = sine; lower index wins drain arbitration.
  logic [2:0]    w_done;
  logic [31:0]   w_res [3];
  logic [2:0]    r_pend_vld;
  logic [31:0]   r_pend_dat [3];
  logic [2:0]    w_drain;
  logic [EW-1:0] w_push_dat;
  logic [EW-1:0] w_head_dat;
  logic [CW-1:0] w_count;
  logic          w_pop;
  logic          w_space;
  logic          r_overflow;

  assign w_done   = {sine_done, mul_done, add_done};
  assign w_res[0] = add_result;
  assign w_res[1] = mul_result;
  assign w_res[2] = sine_result;

  assign w_pop   = result_read && (w_count != '0);
  assign w_space = (w_count != CW'(DEPTH)) || w_pop;

  always_comb begin
    w_drain = '0;
    if (w_space) begin
      if (r_pend_vld[0])      w_drain[0] = 1'b1;
      else if (r_pend_vld[1]) w_drain[1] = 1'b1;
      else if (r_pend_vld[2]) w_drain[2] = 1'b1;
    end
  end

  always_comb begin
    w_push_dat = '0;
    for (int i = 0; i < 3; i++) begin
      if (w_drain[i]) begin
`ifdef OUTCOLLECT_TAG_EN
        w_push_dat = {2'(i + 1), r_pend_dat[i]};
`else
        w_push_dat = r_pend_dat[i];
`endif
      end
    end
  end

  // A done landing on a held, non-draining register is dropped and flagged.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_pend_vld <= '0;
      for (int i = 0; i < 3; i++) r_pend_dat[i] <= '0;
      r_overflow <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (w_done[i]) begin
          if (!r_pend_vld[i] || w_drain[i]) begin
            r_pend_vld[i] <= 1'b1;
            r_pend_dat[i] <= w_res[i];
          end else begin
            r_overflow <= 1'b1;
          end
        end else if (w_drain[i]) begin
          r_pend_vld[i] <= 1'b0;
        end
      end
    end
  end

  outcollect_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .n_rst      (n_rst),
    .i_push_vld (|w_drain),
    .i_push_dat (w_push_dat),
    .i_pop_vld  (w_pop),
    .o_head_dat (w_head_dat),
    .o_count    (w_count)
  );

  assign result_data   = w_head_dat[31:0];
`ifdef OUTCOLLECT_TAG_EN
  assign result_tag    = w_head_dat[33:32];
`else
  assign result_tag    = 2'b00;
`endif
  assign result_valid  = (w_count != '0);
  assign out_fifo_hold = (w_count >= CW'(DEPTH - HOLD_MARGIN));
  assign overflow_err  = r_overflow;
endmodule

// File: tb/tb_outcollect.sv
// Directed bench for outcollect: stimulus pushes expected entries into a queue, a negedge monitor checks every pop.

module tb_outcollect;
  logic        clk = 1'b0;
  logic        n_rst;
  logic        add_done, mul_done, sine_done;
  logic [31:0] add_result, mul_result, sine_result;
  logic        result_read;
  logic [31:0] result_data;
  logic [1:0]  result_tag;
  logic        result_valid;
  logic        out_fifo_hold;
  logic        overflow_err;

  logic [33:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  outcollect #(.DEPTH(8), .HOLD_MARGIN(3)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .add_done      (add_done),
    .mul_done      (mul_done),
    .sine_done     (sine_done),
    .add_result    (add_result),
    .mul_result    (mul_result),
    .sine_result   (sine_result),
    .result_read   (result_read),
    .result_data   (result_data),
    .result_tag    (result_tag),
    .result_valid  (result_valid),
    .out_fifo_hold (out_fifo_hold),
    .overflow_err  (overflow_err)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] exp_tag(input logic [1:0] t);
`ifdef OUTCOLLECT_TAG_EN
    return t;
`else
    return 2'b00;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_entry(input logic [1:0] t, input logic [31:0] d);
    exp_q.push_back({exp_tag(t), d});
  endtask

  // Reads until empty, bounded; leftover data counts as a failed comparison.
  task automatic drain_all;
    result_read = 1'b1;
    for (int i = 0; i < 20 && result_valid; i++) tick();
    result_read = 1'b0;
    check("drain_empty", {31'd0, result_valid}, 32'd0);
  endtask

  always @(negedge clk) begin
    if (n_rst && result_valid && result_read) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL pop_unexpected: got %h with nothing expected", result_data);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        check("pop_data", result_data, e[31:0]);
        check("pop_tag", {30'd0, result_tag}, {30'd0, e[33:32]});
      end
    end
  end

  initial begin
    n_rst = 1'b0;
    {add_done, mul_done, sine_done, result_read} = '0;
    {add_result, mul_result, sine_result} = '0;
    tick(); tick();
    check("rst_valid", {31'd0, result_valid}, 32'd0);
    check("rst_data", result_data, 32'd0);
    check("rst_tag", {30'd0, result_tag}, 32'd0);
    check("rst_hold", {31'd0, out_fifo_hold}, 32'd0);
    check("rst_ovf", {31'd0, overflow_err}, 32'd0);
    n_rst = 1'b1;
    tick();

    // Single add: visible two cycles after the done.
    add_done = 1'b1; add_result = 32'h3F800000; expect_entry(2'b01, 32'h3F800000);
    tick();
    add_done = 1'b0;
    check("lat_t1_valid", {31'd0, result_valid}, 32'd0);
    tick();
    check("lat_t2_valid", {31'd0, result_valid}, 32'd1);
    check("lat_t2_data", result_data, 32'h3F800000);
    result_read = 1'b1;
    tick();
    result_read = 1'b0;
    check("single_pop_empty", {31'd0, result_valid}, 32'd0);

    // Simultaneous dones drain add, mul, sine in order.
    {add_done, mul_done, sine_done} = 3'b111;
    add_result = 32'hAAAA0001; mul_result = 32'hBBBB0002; sine_result = 32'hCCCC0003;
    expect_entry(2'b01, 32'hAAAA0001);
    expect_entry(2'b10, 32'hBBBB0002);
    expect_entry(2'b11, 32'hCCCC0003);
    tick();
    {add_done, mul_done, sine_done} = 3'b000;
    tick(); tick(); tick();
    check("simul_ovf", {31'd0, overflow_err}, 32'd0);
    check("simul_hold", {31'd0, out_fifo_hold}, 32'd0);
    drain_all();

    // Fill to 8 with back-to-back adds; hold rises when count reaches 5.
    for (int k = 0; k < 8; k++) begin
      add_done = 1'b1; add_result = 32'h10000000 + 32'(k);
      expect_entry(2'b01, 32'h10000000 + 32'(k));
      tick();
      check($sformatf("fill_hold_%0d", k), {31'd0, out_fifo_hold}, {31'd0, (k >= 5)});
    end
    add_done = 1'b0;
    tick();
    check("full_hold", {31'd0, out_fifo_hold}, 32'd1);
    check("full_valid", {31'd0, result_valid}, 32'd1);
    check("full_ovf", {31'd0, overflow_err}, 32'd0);
    add_done = 1'b1; add_result = 32'h19999999; expect_entry(2'b01, 32'h19999999);
    tick();
    add_done = 1'b0;
    tick();
    check("ninth_pending_ovf", {31'd0, overflow_err}, 32'd0);
    add_done = 1'b1; add_result = 32'hDEADBEEF;
    tick();
    add_done = 1'b0;
    check("drop_ovf", {31'd0, overflow_err}, 32'd1);
    result_read = 1'b1;
    tick();
    check("full_pushpop_hold", {31'd0, out_fifo_hold}, 32'd1);
    drain_all();

    // Read on empty must not disturb pointers.
    result_read = 1'b1;
    tick();
    result_read = 1'b0;
    check("empty_read_valid", {31'd0, result_valid}, 32'd0);
    add_done = 1'b1; add_result = 32'h55AA55AA; expect_entry(2'b01, 32'h55AA55AA);
    tick();
    add_done = 1'b0;
    tick();
    check("after_empty_read_data", result_data, 32'h55AA55AA);
    drain_all();

    // Interleaved push/pop across pointer wrap, alternating add and mul.
    for (int i = 0; i < 20; i++) begin
      add_done = (i % 2 == 0);
      mul_done = (i % 2 == 1);
      add_result = 32'hA0000000 + 32'(i);
      mul_result = 32'hA0000000 + 32'(i);
      expect_entry((i % 2 == 0) ? 2'b01 : 2'b10, 32'hA0000000 + 32'(i));
      result_read = result_valid;
      tick();
      check($sformatf("wrap_hold_%0d", i), {31'd0, out_fifo_hold}, 32'd0);
    end
    {add_done, mul_done} = 2'b00;
    tick(); tick();
    drain_all();

    // Asynchronous reset with four entries queued.
    for (int i = 0; i < 4; i++) begin
      add_done = 1'b1; add_result = 32'hE0000000 + 32'(i);
      tick();
    end
    add_done = 1'b0;
    tick(); tick();
    check("prerst_valid", {31'd0, result_valid}, 32'd1);
    n_rst = 1'b0;
    #1;
    check("arst_valid", {31'd0, result_valid}, 32'd0);
    check("arst_data", result_data, 32'd0);
    check("arst_tag", {30'd0, result_tag}, 32'd0);
    check("arst_hold", {31'd0, out_fifo_hold}, 32'd0);
    check("arst_ovf", {31'd0, overflow_err}, 32'd0);
    exp_q.delete();
    tick();
    n_rst = 1'b1;
    tick();
    add_done = 1'b1; add_result = 32'h12345678; expect_entry(2'b01, 32'h12345678);
    tick();
    add_done = 1'b0;
    tick();
    check("postrst_data", result_data, 32'h12345678);
    result_read = 1'b1;
    tick();
    result_read = 1'b0;
    check("postrst_sole", {31'd0, result_valid}, 32'd0);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
